lif_activation_array: RTL and testbench

Multi-channel leaky integrate-and-fire activation stage that follows the systolic array's partial-sum outputs. Each of NUM_CH lanes integrates a signed input current into a persistent membrane potential, applies leak, fires when the potential reaches a shared threshold, and then enforces a programmable refractory period. Per-lane saturating spike counts are kept for rate readout. A valid/ready handshake with one output register stage sits between the array drain and the spike router.

---
 rtl/lif_pkg.sv | 11 +
 rtl/lif_neuron_lane.sv | 58 +++++
 rtl/lif_activation_array.sv | 62 ++++++
 tb/tb_lif_activation_array.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: reset-mode encodings and signed saturation shared by the LIF lanes
package lif_pkg;
  localparam logic RESET_ZERO = 1'b0;
  localparam logic RESET_SUB = 1'b1;
  function automatic logic signed [63:0] sat(input logic signed [63:0] s, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/lif_neuron_lane.sv
// lif_neuron_lane: one neuron (potential v, refractory r, spike count) plus its combinational integrate/leak/fire update; spike is next-step combinational
module lif_neuron_lane
  import lif_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TIMER_WIDTH = 5,
  parameter int REFRAC_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   current,
  input  logic [DATA_WIDTH-1:0]   threshold,
  input  logic [DATA_WIDTH-1:0]   leak,
  input  logic                    reset_mode,
  input  logic [REFRAC_WIDTH-1:0] refrac_period,
  output logic                    spike,
  output logic [DATA_WIDTH-1:0]   membrane,
  output logic [TIMER_WIDTH-1:0]  count
);
  logic signed [DATA_WIDTH-1:0] v, thr, vs, vn;
  logic signed [DATA_WIDTH+1:0] s, mag, lk, l;
  logic signed [63:0] wide;
  logic [REFRAC_WIDTH-1:0] r;
  always_comb begin
    thr = threshold;
    s = {{2{v[DATA_WIDTH-1]}}, v} + {{2{current[DATA_WIDTH-1]}}, current};
    mag = s[DATA_WIDTH+1] ? -s : s;
    lk = {2'b00, leak};
    l = lk >= mag ? '0 : s[DATA_WIDTH+1] ? s + lk : s - lk;
    wide = sat(64'(l), DATA_WIDTH);
    vs = wide[DATA_WIDTH-1:0];
    spike = (r == '0) && (wide >= 64'(thr));
    vn = spike ? (reset_mode == RESET_SUB ? vs - thr : '0) : vs;
  end
  assign membrane = v;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      r <= '0;
      count <= '0;
    end else if (clear) begin
      v <= '0;
      r <= '0;
      count <= '0;
    end else if (en) begin
      if (r != '0) r <= r - REFRAC_WIDTH'(1);
      else begin
        v <= vn;
        if (spike) begin
          r <= refrac_period;
          count <= count + TIMER_WIDTH'(~&count);
        end
      end
    end
  end
endmodule

// File: rtl/lif_activation_array.sv
// lif_activation_array: NUM_CH LIF lanes behind a valid/ready handshake with one output register stage (spike/membrane/accumulated_spikes registered with out_valid)
module lif_activation_array
  import lif_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMER_WIDTH = 5,
  parameter int REFRAC_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  in_current,
  input  logic [DATA_WIDTH-1:0]         in_threshold,
  input  logic [DATA_WIDTH-1:0]         leak,
  input  logic                          reset_mode,
  input  logic [REFRAC_WIDTH-1:0]       refrac_period,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0]             spike,
  output logic [NUM_CH*TIMER_WIDTH-1:0] accumulated_spikes,
  output logic [NUM_CH*DATA_WIDTH-1:0]  membrane
);
  logic acc;
  logic [NUM_CH-1:0] spike_d;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      spike <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      spike <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      spike <= spike_d;
    end else if (out_ready) out_valid <= 1'b0;
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    lif_neuron_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .TIMER_WIDTH(TIMER_WIDTH),
      .REFRAC_WIDTH(REFRAC_WIDTH)
    ) u_lane (
      .clk(clk),
      .rstn(rstn),
      .en(acc),
      .clear(clear),
      .current(in_current[k*DATA_WIDTH +: DATA_WIDTH]),
      .threshold(in_threshold),
      .leak(leak),
      .reset_mode(reset_mode),
      .refrac_period(refrac_period),
      .spike(spike_d[k]),
      .membrane(membrane[k*DATA_WIDTH +: DATA_WIDTH]),
      .count(accumulated_spikes[k*TIMER_WIDTH +: TIMER_WIDTH])
    );
  end
endmodule

// File: tb/tb_lif_activation_array.sv
// tb_lif_activation_array: directed and random stimulus checked every cycle against an integer behavioural model of the LIF array
module tb_lif_activation_array;
  localparam int N = 4, DW = 16, TW = 5, RW = 3;
  logic clk = 0, rstn = 0, in_valid = 0, reset_mode = 0, clear = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [N*DW-1:0] in_current = '0;
  logic [DW-1:0] in_threshold = 16'd100, leak = '0;
  logic [RW-1:0] refrac_period = '0;
  logic [N-1:0] spike;
  logic [N*TW-1:0] accumulated_spikes;
  logic [N*DW-1:0] membrane;
  int errors = 0, checks = 0;
  int mv[N], mr[N], mc[N];
  bit ms[N];
  bit mov = 0;
  always #5 clk = ~clk;
  lif_activation_array #(.NUM_CH(N), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .REFRAC_WIDTH(RW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
    .in_threshold(in_threshold), .leak(leak), .reset_mode(reset_mode), .refrac_period(refrac_period),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .spike(spike),
    .accumulated_spikes(accumulated_spikes), .membrane(membrane)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      mr[k] = 0;
      mc[k] = 0;
      ms[k] = 0;
    end
    mov = 0;
  endfunction
  function automatic void model_update();
    int s, th, lk, mag;
    th = int'($signed(in_threshold));
    lk = int'(leak);
    if (clear) model_reset();
    else if (in_valid && (!mov || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (mr[k] > 0) begin
          mr[k]--;
          ms[k] = 0;
        end else begin
          s = mv[k] + int'($signed(in_current[k*DW +: DW]));
          mag = s < 0 ? -s : s;
          if (lk >= mag) s = 0;
          else s = s > 0 ? s - lk : s + lk;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          ms[k] = s >= th;
          if (ms[k]) begin
            mv[k] = reset_mode ? s - th : 0;
            mr[k] = int'(refrac_period);
            mc[k] = mc[k] < 31 ? mc[k] + 1 : 31;
          end else mv[k] = s;
        end
      end
      mov = 1;
    end else if (out_ready) mov = 0;
  endfunction
  function automatic logic [N*DW-1:0] exp_mem();
    logic [N*DW-1:0] e;
    int t;
    for (int k = 0; k < N; k++) begin
      t = mv[k];
      e[k*DW +: DW] = t[DW-1:0];
    end
    return e;
  endfunction
  function automatic logic [N*TW-1:0] exp_acc();
    logic [N*TW-1:0] e;
    int t;
    for (int k = 0; k < N; k++) begin
      t = mc[k];
      e[k*TW +: TW] = t[TW-1:0];
    end
    return e;
  endfunction
  function automatic logic [N-1:0] exp_spk();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = ms[k];
    return e;
  endfunction
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(mov));
    chk("in_ready", 64'(in_ready), 64'(!mov || out_ready));
    chk("spike", 64'(spike), 64'(exp_spk()));
    chk("membrane", 64'(membrane), 64'(exp_mem()));
    chk("accumulated_spikes", 64'(accumulated_spikes), 64'(exp_acc()));
  end
  task automatic step(input bit v, input bit r, input bit c);
    #1;
    in_valid = v;
    out_ready = r;
    clear = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic set_cur(input int c0, input int co);
    for (int k = 0; k < N; k++) in_current[k*DW +: DW] = k == 0 ? DW'(c0) : DW'(co);
  endtask
  task automatic do_reset();
    #1;
    rstn = 0;
    model_reset();
    @(negedge clk);
    #1;
    rstn = 1;
  endtask
  int mem_mode1[3] = '{50, 100, 150};
  int mem_refr[4] = '{400, 400, 400, 800};
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_membrane", 64'(membrane), 64'd0);
    chk("reset_acc", 64'(accumulated_spikes), 64'd0);
    #1;
    rstn = 1;
    repeat (2) step(0, 1, 0);
    set_cur(40, 0);
    for (int n = 1; n <= 6; n++) begin
      step(1, 1, 0);
      if (n == 2) chk("int_mem80", 64'(membrane[DW-1:0]), 64'd80);
      if (n == 3) chk("fire3_spike", 64'(spike[0]), 64'd1);
      if (n == 3) chk("fire3_mem0", 64'(membrane[DW-1:0]), 64'd0);
      if (n == 6) chk("count2", 64'(accumulated_spikes[TW-1:0]), 64'd2);
    end
    step(0, 1, 1);
    chk("clear_mem", 64'(membrane), 64'd0);
    chk("clear_acc", 64'(accumulated_spikes), 64'd0);
    reset_mode = 1;
    set_cur(150, 0);
    for (int n = 0; n < 3; n++) begin
      step(1, 1, 0);
      chk("mode1_spike", 64'(spike[0]), 64'd1);
      chk("mode1_mem", 64'(membrane[DW-1:0]), 64'(mem_mode1[n]));
    end
    step(0, 1, 1);
    reset_mode = 0;
    set_cur(5, 0);
    step(1, 1, 0);
    leak = 16'd10;
    set_cur(0, 0);
    step(1, 1, 0);
    chk("leak_to_zero", 64'(membrane[DW-1:0]), 64'd0);
    leak = 0;
    step(0, 1, 1);
    in_threshold = 16'd32767;
    set_cur(32000, 0);
    step(1, 1, 0);
    chk("sat_pre", 64'(membrane[DW-1:0]), 64'd32000);
    reset_mode = 1;
    in_threshold = 16'd100;
    set_cur(32767, 0);
    step(1, 1, 0);
    chk("sat_spike", 64'(spike[0]), 64'd1);
    chk("sat_mem", 64'(membrane[DW-1:0]), 64'd32667);
    step(0, 1, 1);
    refrac_period = 3'd2;
    set_cur(500, 0);
    for (int n = 0; n < 4; n++) begin
      step(1, 1, 0);
      chk("refrac_spike", 64'(spike[0]), (n == 0 || n == 3) ? 64'd1 : 64'd0);
      chk("refrac_mem", 64'(membrane[DW-1:0]), 64'(mem_refr[n]));
    end
    refrac_period = 0;
    reset_mode = 0;
    step(0, 1, 1);
    set_cur(40, 0);
    step(1, 1, 0);
    repeat (3) begin
      step(1, 0, 0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_mem", 64'(membrane[DW-1:0]), 64'd40);
    end
    step(1, 1, 0);
    chk("bp_release_mem", 64'(membrane[DW-1:0]), 64'd80);
    step(0, 1, 1);
    set_cur(100, 100);
    repeat (40) step(1, 1, 0);
    chk("cnt_sat", 64'(accumulated_spikes), 64'({N{5'd31}}));
    set_cur(50, 50);
    step(1, 1, 1);
    chk("clr_valid_ov", 64'(out_valid), 64'd0);
    chk("clr_valid_mem", 64'(membrane), 64'd0);
    chk("clr_valid_acc", 64'(accumulated_spikes), 64'd0);
    chk("clr_valid_spk", 64'(spike), 64'd0);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        in_threshold = $urandom_range(0, 15) == 0 ? DW'($urandom_range(1, 32767)) : DW'($urandom_range(1, 400));
        leak = DW'($urandom_range(0, 30));
        reset_mode = 1'($urandom_range(0, 1));
        refrac_period = RW'($urandom_range(0, 3));
        for (int k = 0; k < N; k++)
          in_current[k*DW +: DW] = $urandom_range(0, 7) == 0 ? DW'($urandom) : DW'(int'($urandom_range(0, 300)) - 100);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
